// File: rtl/number_entry_if.sv
// number_entry_if
//   Key-event handshake between the keypad decoder (master) and the
//   number_entry accumulator (slave).
//   key_valid : master -> slave, a key event is present
//   key_code  : master -> slave, 0-15 digit, 16 BACKSPACE, 17 NEGATE,
//               18 CLEAR, 19-31 reserved
//   key_ready : slave -> master, the accumulator can take a key this cycle
interface number_entry_if;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/number_entry.sv
// number_entry
//   Keypad-entry accumulator for the calculator datapath. Builds a signed
//   operand from decoded key events in decimal or hexadecimal entry mode
//   and feeds the seven-segment display driver. Decimal backspace runs a
//   restoring divide-by-10 over DIV_CYCLES clocks, during which no key is
//   accepted.
//   clock   : system clock
//   reset_n : synchronous, active-low reset
//   key     : key-event handshake (slave side of number_entry_if)
//   switch  : entry base, 0 = decimal, 1 = hexadecimal (sampled on accept)
//   value   : two's-complement operand, neg ? -mag : mag
//   error   : sticky overflow flag, cleared only by CLEAR or reset
module number_entry #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    number_entry_if.slave    key,
    input  logic             switch,
    output logic [WIDTH-1:0] value,
    output logic             error
);

    localparam int CW = $clog2(DIV_CYCLES);

    localparam logic [4:0] KEY_BACKSPACE = 5'd16;
    localparam logic [4:0] KEY_NEGATE    = 5'd17;
    localparam logic [4:0] KEY_CLEAR     = 5'd18;

    // Largest magnitude that keeps the operand representable as a positive
    // and negative number, held at the width of the decimal product.
    localparam logic [WIDTH+3:0] MAG_MAX = {5'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic {
        S_IDLE,
        S_DIV
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] q_q, q_d;      // dividend shifting out / quotient shifting in
    logic [4:0]       r_q, r_d;      // partial remainder, always < 10
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [3:0]       digit;
    logic [WIDTH+3:0] dec_t;
    logic             hex_full;
    logic [4:0]       r_shift;
    logic             sub_ok;
    logic [4:0]       r_next;
    logic [WIDTH-1:0] q_next;

    assign key.key_ready = (state_q == S_IDLE);
    assign accept        = key.key_valid && key.key_ready;
    assign digit         = key.key_code[3:0];

    // mag*10 + d without a multiplier; four extra bits catch the overflow.
    assign dec_t = ({4'b0, mag_q} << 3) + ({4'b0, mag_q} << 1) + (WIDTH+4)'(digit);

    // Any set bit in the top nibble plus sign position would be pushed past
    // the largest legal magnitude by another hex digit.
    assign hex_full = |mag_q[WIDTH-1:WIDTH-5];

    // One restoring-division step: bring down the next dividend bit and
    // subtract 10 when the partial remainder allows it.
    assign r_shift = {r_q[3:0], q_q[WIDTH-1]};
    assign sub_ok  = (r_shift >= 5'd10);
    assign r_next  = sub_ok ? (r_shift - 5'd10) : r_shift;
    assign q_next  = {q_q[WIDTH-2:0], sub_ok};

    always_comb begin
        // NOTE: every signal driven here gets a hold default first so no
        // path through the case/if tree leaves it unassigned (no latches).
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        err_d   = err_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (key.key_code == KEY_CLEAR) begin
                        mag_d = '0;
                        neg_d = 1'b0;
                        err_d = 1'b0;
                    end else if (!err_q) begin
                        // While the error flag is up every other key is
                        // swallowed so the display keeps the last good operand.
                        if (!key.key_code[4]) begin
                            if (switch) begin
                                if (hex_full) err_d = 1'b1;
                                else          mag_d = {mag_q[WIDTH-5:0], digit};
                            end else if (digit < 4'd10) begin
                                if (dec_t > MAG_MAX) err_d = 1'b1;
                                else                 mag_d = dec_t[WIDTH-1:0];
                            end
                        end else if (key.key_code == KEY_BACKSPACE) begin
                            if (switch) begin
                                mag_d = mag_q >> 4;
                            end else begin
                                q_d     = mag_q;
                                r_d     = '0;
                                cnt_d   = '0;
                                state_d = S_DIV;
                            end
                        end else if (key.key_code == KEY_NEGATE) begin
                            neg_d = ~neg_q;
                        end
                    end
                end
            end
            S_DIV: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                    mag_d   = q_next;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value = neg_q ? (~mag_q + WIDTH'(1)) : mag_q;
    assign error = err_q;

endmodule

// File: doc/number_entry.md
Name: number_entry

Overview:
- Keypad-entry accumulator for the calculator datapath.
- Sits directly upstream of the seven-segment display driver and drives its `value` and `error` inputs.
- Consumes decoded key events (digits, backspace, negate, clear) via a valid/ready handshake and builds a signed 32-bit operand in decimal or hexadecimal entry mode.
- Decimal backspace uses an iterative divide-by-10, so the block has a multi-cycle busy phase.

Parameters:
- WIDTH, 32, operand width in bits; `value` is two's complement of this width.
- DIV_CYCLES, 32, iterations of the restoring divide-by-10; must equal WIDTH.

Ports:
- clock  input  1  system clock, 50 MHz
- reset_n  input  1  synchronous, active-low reset
- key_valid  input  1  key event present
- key_code  input  5  0-15 digit; 16 BACKSPACE; 17 NEGATE; 18 CLEAR; 19-31 reserved
- key_ready  output  1  block can accept a key this cycle
- switch  input  1  entry base: 0 = decimal, 1 = hexadecimal
- value  output  WIDTH  signed operand = neg ? -mag : mag
- error  output  1  sticky overflow flag

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a clock edge):
  - mag=0, neg=0, error=0, state=IDLE.
  - key_ready=1 and value=0 on the following cycle.
  - Reset overrides everything, including an in-progress divide.
- Internal state:
  - mag: unsigned magnitude, WIDTH bits, always ≤ 2^31-1.
  - neg: sign flag.
  - error: sticky flag.
  - q/r: divider registers.
  - counter: 5-bit iteration count.
- A key is accepted when key_valid && key_ready at a rising edge. key_valid while key_ready=0 is not consumed; the source must hold it until ready.
- States:
  - IDLE: key_ready=1.
  - DIV: key_ready=0.
- In IDLE, on an accepted key, effects appear on value/error at the same edge (1-cycle latency):
  - Digit d, decimal mode:
    - d≥10: ignored.
    - Otherwise compute t = mag*10 + d in 36 bits, with *10 done as (mag<<3)+(mag<<1).
    - t > 2^31-1: error←1, mag unchanged.
    - Else mag←t.
  - Digit d, hex mode:
    - mag[WIDTH-1:WIDTH-5] ≠ 0: error←1, mag unchanged.
    - Else mag←(mag<<4)|d.
  - NEGATE: neg←~neg. When mag=0, value stays 0.
  - CLEAR: mag←0, neg←0, error←0.
  - BACKSPACE, hex mode: mag←mag>>4.
  - BACKSPACE, decimal mode:
    - Load the divider with mag; go to DIV.
    - mag=0 still goes through DIV; the result is 0.
  - Reserved codes (19-31): accepted and ignored.
- While error=1:
  - Every key except CLEAR is accepted and ignored.
  - value holds the last valid operand.
  - error drives the display error message.
- DIV state:
  - Restoring divide by 10, one quotient bit per cycle, MSB first.
  - key_ready=0 for exactly DIV_CYCLES cycles following the accept edge.
  - At the edge ending the last iteration: mag←quotient, state←IDLE, key_ready=1 in the next cycle.
  - neg is unchanged.
  - value keeps showing the old operand throughout DIV.
- Mode change (switch toggled mid-entry): mag is not altered. Subsequent digits use the new base. The display reinterprets the same binary value.
- switch is sampled only at key-accept edges; a toggle during DIV does not affect the in-progress divide.
- Arithmetic: value = neg ? (~mag + 1) : mag, computed combinationally from registers. mag never exceeds 2^31-1, so value never equals -2^31 and no sign overflow is possible.
- Simultaneous key_valid and reset_n=0: reset wins; the key is not consumed.

Test Plan:
- Reset, switch=0, keys 1,2,3 → value=123 (0x0000007B), error=0, key_ready constantly 1.
- From 123: NEGATE → value=0xFFFFFF85. BACKSPACE → key_ready low exactly 32 cycles, value stays 0xFFFFFF85, then value=0xFFFFFFF4 (-12).
- switch=1, CLEAR, keys F,F → value=255. BACKSPACE → value=15 next cycle, key_ready never drops. switch=0, key A → ignored, value=15.
- Decimal keys 2,1,4,7,4,8,3,6,4 → value=214748364. Key 7 → value=2147483647, error=0. Key 0 → error=1, value stays 2147483647. Key 5 → ignored. CLEAR → value=0, error=0.
- Hex keys 7,F,F,F,F,F,F,F → value=0x7FFFFFFF. Key 1 → error=1, value unchanged. NEGATE → ignored while error=1.
- Start decimal BACKSPACE on 999; assert reset_n=0 at cycle 10 of DIV → next cycle value=0, error=0, key_ready=1. Hold key_valid during DIV → key consumed only after key_ready returns.
